// File: rtl/inst_trace_buffer.sv
// Trigger-based instruction trace buffer: captures {pc, inst} every cycle once armed,
// freezes POST entries after a PC match, then drains oldest-first over valid/ready.
module inst_trace_buffer #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 16,
  parameter int POST     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [ADDR_LEN-1:0]        trig_pc,
  input  logic [ADDR_LEN-1:0]        cpu_pc,
  input  logic [DATA_LEN-1:0]        cpu_inst,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ADDR_LEN-1:0]        rd_pc,
  output logic [DATA_LEN-1:0]        rd_inst,
  output logic                       rd_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wrapped,
  output logic [1:0]                 state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_POST   = 2'd2;
  localparam logic [1:0] S_FROZEN = 2'd3;

  // Read port handshake: an entry transfers on a rising edge where rd_valid && rd_ready;
  // rd_valid only rises in FROZEN and the head entry is held stable until it transfers.

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       post_q, post_d;
  logic                wrapped_q, wrapped_d;

  logic [ADDR_LEN-1:0] pc_mem_q   [DEPTH];
  logic [DATA_LEN-1:0] inst_mem_q [DEPTH];

  logic capture;
  logic full;
  logic hit;
  logic pop;

  assign capture  = (state_q == S_ARMED) || (state_q == S_POST);
  assign full     = (count_q == CW'(DEPTH));
  assign hit      = trig_en && (cpu_pc == trig_pc);
  assign rd_valid = (state_q == S_FROZEN) && (count_q != '0);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    post_d    = post_q;
    wrapped_d = wrapped_q;

    // Capture bookkeeping common to ARMED and POST; a full buffer drops its oldest entry.
    if (capture) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (full) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        wrapped_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          post_d    = '0;
          wrapped_d = 1'b0;
          state_d   = S_ARMED;
        end
      end
      S_ARMED: begin
        if (hit) begin
          if (POST == 0) begin
            state_d = S_FROZEN;
          end else begin
            post_d  = CW'(POST);
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        post_d = post_q - CW'(1);
        if (post_q <= CW'(1)) begin
          state_d = S_FROZEN;
        end
      end
      default: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      post_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      post_q    <= post_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Storage needs no reset: nothing reads it until it has been written since arm.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      pc_mem_q[wr_ptr_q]   <= cpu_pc;
      inst_mem_q[wr_ptr_q] <= cpu_inst;
    end
  end

  assign rd_pc   = rd_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign rd_inst = rd_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign rd_last = rd_valid && (count_q == CW'(1));
  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign state   = state_q;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: two DEPTH=8 instances (POST=2 and POST=0) checked against
// a trace model computed directly from the stimulus list.
module tb_inst_trace_buffer;

  localparam int DEPTH = 8;
  localparam int POST  = 2;

  logic        clk = 1'b0;
  logic        rst, arm, arm0, trig_en, rd_ready, rd_ready0;
  logic [31:0] trig_pc, cpu_pc, cpu_inst;

  logic        rd_valid, rd_last, wrapped;
  logic [31:0] rd_pc, rd_inst;
  logic [3:0]  count;
  logic [1:0]  state;

  logic        rd_valid0, rd_last0, wrapped0;
  logic [31:0] rd_pc0, rd_inst0;
  logic [3:0]  count0;
  logic [1:0]  state0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] stim_q[$];
  logic [31:0] exp_q[$];
  bit          exp_wrapped;

  inst_trace_buffer #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_last(rd_last), .count(count),
    .wrapped(wrapped), .state(state)
  );

  inst_trace_buffer #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH(DEPTH), .POST(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .trig_en(trig_en), .trig_pc(trig_pc),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
    .rd_pc(rd_pc0), .rd_inst(rd_inst0), .rd_last(rd_last0), .count(count0),
    .wrapped(wrapped0), .state(state0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hFFFF_0000;
  endfunction

  // Trace model: capture runs through trigger index + post entries; keep the newest DEPTH.
  task automatic build_expected(input int post, input bit ten, input logic [31:0] tpc,
                                output bit frz);
    int n;
    int first;
    n   = stim_q.size();
    frz = 1'b0;
    if (ten) begin
      for (int i = 0; i < stim_q.size(); i++) begin
        if (stim_q[i] == tpc && i + post + 1 <= stim_q.size()) begin
          n   = i + post + 1;
          frz = 1'b1;
          break;
        end
      end
    end
    exp_q.delete();
    first = (n > DEPTH) ? n - DEPTH : 0;
    for (int i = first; i < n; i++) exp_q.push_back(stim_q[i]);
    exp_wrapped = (n > DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_checks++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped got %b want 0", wrapped); end
    n_checks++; if (rd_pc !== 32'd0 || rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pc got %h/%b want 0/0", rd_pc, rd_last); end
    n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL reset_state0 got %0d want 0", state0); end
  endtask

  // Arms the POST=2 instance and feeds stim_q until it freezes; arm is pulsed at random
  // during capture, where it must be ignored.
  task automatic run_capture(input string tag, input logic [31:0] tpc, input bit ten);
    bit frz;
    trig_pc = tpc;
    trig_en = ten;
    build_expected(POST, ten, tpc, frz);
    arm      = 1'b1;
    cpu_pc   = tpc;
    cpu_inst = inst_of(tpc);
    tick();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL %s_armed got %0d want 1", tag, state); end
    for (int i = 0; i < stim_q.size(); i++) begin
      cpu_pc   = stim_q[i];
      cpu_inst = inst_of(stim_q[i]);
      arm      = 1'($urandom_range(0, 1));
      tick();
      if (state == 2'd3) break;
    end
    arm = 1'b0;
    n_checks++; if (state !== (frz ? 2'd3 : 2'd1)) begin n_fail++; $display("FAIL %s_state got %0d want %0d", tag, state, frz ? 3 : 1); end
    n_checks++; if (count !== 4'(exp_q.size())) begin n_fail++; $display("FAIL %s_count got %0d want %0d", tag, count, exp_q.size()); end
    n_checks++; if (wrapped !== exp_wrapped) begin n_fail++; $display("FAIL %s_wrapped got %b want %b", tag, wrapped, exp_wrapped); end
  endtask

  // mode 0: always ready, 1: random ready, 2: toggling ready.
  task automatic drain(input string tag, input int mode);
    int budget = 200;
    rd_ready = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      n_checks++; if (rd_valid !== 1'b1 || rd_pc !== exp_q[0] || rd_inst !== inst_of(exp_q[0])) begin
        n_fail++; $display("FAIL %s_head got v=%b pc=%h inst=%h want v=1 pc=%h", tag, rd_valid, rd_pc, rd_inst, exp_q[0]);
      end
      n_checks++; if (rd_last !== (exp_q.size() == 1) || count !== 4'(exp_q.size())) begin
        n_fail++; $display("FAIL %s_last got last=%b count=%0d want count=%0d", tag, rd_last, count, exp_q.size());
      end
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = ~rd_ready;
      endcase
      arm      = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_pc   = $urandom;
      cpu_inst = $urandom;
      tick();
      if (rd_ready) void'(exp_q.pop_front());
    end
    rd_ready = 1'b0;
    arm      = 1'b0;
    n_checks++; if (budget == 0) begin n_fail++; $display("FAIL %s_timeout got %0d left want 0", tag, exp_q.size()); end
    n_checks++; if (state !== 2'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s_idle got state=%0d v=%b want 0/0", tag, state, rd_valid); end
  endtask

  task automatic fill_linear(input logic [31:0] base, input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(base + 32'(4 * i));
  endtask

  task automatic test_basic();
    fill_linear(32'h0, 12);
    run_capture("basic", 32'h10, 1'b1);
    drain("basic", 0);
  endtask

  task automatic test_wrap();
    fill_linear(32'h0, 24);
    run_capture("wrap", 32'h40, 1'b1);
    n_checks++; if (rd_pc !== 32'h2C) begin n_fail++; $display("FAIL wrap_oldest got %h want 2c", rd_pc); end
    drain("wrap", 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] head;
    fill_linear(32'h200, 14);
    run_capture("bp", 32'h214, 1'b1);
    head     = exp_q[0];
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_pc = $urandom;
      tick();
      n_checks++; if (rd_pc !== head || state !== 2'd3 || count !== 4'(exp_q.size())) begin
        n_fail++; $display("FAIL bp_hold got pc=%h st=%0d cnt=%0d want pc=%h st=3", rd_pc, state, count, head);
      end
    end
    drain("bp_toggle", 2);
  endtask

  task automatic test_random();
    int idx;
    for (int r = 0; r < 4; r++) begin
      idx = $urandom_range(0, 20);
      fill_linear($urandom & 32'hFFFF_FF00, idx + POST + 1 + $urandom_range(0, 5));
      run_capture("rand", stim_q[idx], 1'b1);
      drain("rand", 1);
    end
  endtask

  task automatic test_reset_mid_post();
    trig_pc = 32'h10;
    trig_en = 1'b1;
    arm     = 1'b1;
    cpu_pc  = 32'h0;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_pc = 32'(4 * i);
      tick();
    end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL midpost_in_post got %0d want 2", state); end
    cpu_pc = 32'h14;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (state !== 2'd0 || count !== 4'd0 || wrapped !== 1'b0) begin
      n_fail++; $display("FAIL midpost_reset got st=%0d cnt=%0d w=%b want 0/0/0", state, count, wrapped);
    end
    fill_linear(32'h100, 10);
    run_capture("rearm", 32'h108, 1'b1);
    drain("rearm", 0);
  endtask

  task automatic test_no_trigger();
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back($urandom);
    run_capture("notrig", 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_post_zero();
    bit frz;
    int budget = 100;
    fill_linear(32'h400, 12);
    trig_pc = stim_q[5];
    trig_en = 1'b1;
    build_expected(0, 1'b1, trig_pc, frz);
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    for (int i = 0; i < stim_q.size(); i++) begin
      cpu_pc   = stim_q[i];
      cpu_inst = inst_of(stim_q[i]);
      tick();
      if (state0 == 2'd3) break;
    end
    n_checks++; if (state0 !== 2'd3 || count0 !== 4'(exp_q.size())) begin
      n_fail++; $display("FAIL post0_freeze got st=%0d cnt=%0d want 3/%0d", state0, count0, exp_q.size());
    end
    rd_ready0 = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      n_checks++; if (rd_pc0 !== exp_q[0] || rd_last0 !== (exp_q.size() == 1)) begin
        n_fail++; $display("FAIL post0_head got pc=%h last=%b want pc=%h", rd_pc0, rd_last0, exp_q[0]);
      end
      tick();
      void'(exp_q.pop_front());
    end
    rd_ready0 = 1'b0;
    n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL post0_idle got %0d want 0", state0); end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; arm0 = 1'b0; trig_en = 1'b0; trig_pc = '0;
    cpu_pc = '0; cpu_inst = '0; rd_ready = 1'b0; rd_ready0 = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid_post();
    test_random();
    test_no_trigger();
    test_post_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
